// File: rtl/mem_ctrl_if.sv
// rtl/mem_ctrl_if.sv - request, status and RAM-port signal bundle for mem_ctrl
//
// Purpose: groups the IF fetch port, the MEM load/store port and the
// byte-wide RAM port that mem_ctrl arbitrates between.
// Modports:
//   slave  - the controller (mem_ctrl): takes requests and ram_rdata,
//            drives status, returned data and the RAM address/write strobes.
//   master - the requesters plus RAM side (pipeline stages, RAM model).
// Signals:
//   if_req/if_addr -> if_stat/if_data              IF word fetch
//   mem_en/mem_sel/mem_type/mem_addr/mem_dout
//                  -> mem_stat/mem_din             MEM load/store
//   ram_addr/ram_wr/ram_wdata <- ram_rdata         byte-serial RAM port

interface mem_ctrl_if #(
  parameter int RAM_ADDR_W = 17
);
  logic                  if_req;
  logic [31:0]           if_addr;
  logic [1:0]            if_stat;
  logic [31:0]           if_data;
  logic                  mem_en;
  logic                  mem_sel;
  logic [1:0]            mem_type;
  logic [31:0]           mem_addr;
  logic [31:0]           mem_dout;
  logic [1:0]            mem_stat;
  logic [31:0]           mem_din;
  logic [RAM_ADDR_W-1:0] ram_addr;
  logic                  ram_wr;
  logic [7:0]            ram_wdata;
  logic [7:0]            ram_rdata;

  modport slave (
    input  if_req, if_addr, mem_en, mem_sel, mem_type, mem_addr, mem_dout,
    input  ram_rdata,
    output if_stat, if_data, mem_stat, mem_din,
    output ram_addr, ram_wr, ram_wdata
  );

  modport master (
    output if_req, if_addr, mem_en, mem_sel, mem_type, mem_addr, mem_dout,
    output ram_rdata,
    input  if_stat, if_data, mem_stat, mem_din,
    input  ram_addr, ram_wr, ram_wdata
  );
endinterface

// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - IF/MEM arbiter and byte-serial sequencer for the RAM port
//
// Purpose: shares one byte-wide RAM port between instruction fetch and the
// MEM load/store path. MEM has fixed priority. Each byte/half/word request
// becomes 1/2/4 consecutive RAM cycles; data is little-endian.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous, active-high reset
//   bus  - mem_ctrl_if.slave (requests in, status/data/RAM strobes out)
// Status encoding on if_stat/mem_stat: 00 Idle, 01 Busy, 10 Handled.
// All outputs are registered.
// Optional feature: define MEMCTRL_IFETCH_BUF_EN to add a one-entry fetch
// buffer that answers a repeated aligned IF fetch without touching RAM.

module mem_ctrl #(
  parameter int RAM_ADDR_W = 17
) (
  input  logic         clk,
  input  logic         rst,
  mem_ctrl_if.slave    bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [1:0] O_NONE = 2'd0;
  localparam logic [1:0] O_IF   = 2'd1;
  localparam logic [1:0] O_MEM  = 2'd2;

  localparam logic [1:0] ST_IDLE    = 2'b00;
  localparam logic [1:0] ST_BUSY    = 2'b01;
  localparam logic [1:0] ST_HANDLED = 2'b10;

  logic [1:0]            state, nxt_state;
  logic [1:0]            owner, nxt_owner;
  logic [2:0]            cnt, cnt_nx, len, req_len;
  logic [RAM_ADDR_W-1:0] base, addr_nx;
  logic                  sel;
  logic [31:0]           wdata_q;
  logic [31:0]           rd_buf, done_word;
  logic [1:0]            lane;
  logic                  rd_last, wr_last;
  logic                  fb_hit;

  // Upper request-address bits are intentionally dropped by truncation.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.if_addr[31:RAM_ADDR_W], bus.mem_addr[31:RAM_ADDR_W]};

`ifdef MEMCTRL_IFETCH_BUF_EN
  logic                  fb_valid;
  logic [RAM_ADDR_W-3:0] fb_tag;
  logic [31:0]           fb_data;
  // Only aligned fetches are cached, so a hit always returns a whole word.
  assign fb_hit = fb_valid && (bus.if_addr[1:0] == 2'b00) &&
                  (bus.if_addr[RAM_ADDR_W-1:2] == fb_tag);
`else
  assign fb_hit = 1'b0;
`endif

  always_comb begin
    case (bus.mem_type)
      2'b00:   req_len = 3'd1;
      2'b01:   req_len = 3'd2;
      default: req_len = 3'd4;
    endcase
  end

  assign cnt_nx  = cnt + 3'd1;
  assign addr_nx = base + RAM_ADDR_W'(cnt_nx);
  // In BUSY read, the byte arriving now belongs to the address issued one
  // cycle earlier, i.e. lane cnt-1.
  assign lane    = cnt[1:0] - 2'd1;
  assign rd_last = !sel && (cnt == len);
  assign wr_last = sel && (cnt == len - 3'd1);

  always_comb begin
    done_word = rd_buf;
    done_word[{lane, 3'b000} +: 8] = bus.ram_rdata;
  end

  always_comb begin
    nxt_state = state;
    nxt_owner = owner;
    case (state)
      S_IDLE: begin
        if (bus.mem_en) begin
          nxt_state = S_BUSY;
          nxt_owner = O_MEM;
        end else if (bus.if_req) begin
          nxt_state = fb_hit ? S_DONE : S_BUSY;
          nxt_owner = O_IF;
        end
      end
      S_BUSY: begin
        if (rd_last || wr_last) nxt_state = S_DONE;
      end
      S_DONE: begin
        nxt_state = S_IDLE;
        nxt_owner = O_NONE;
      end
      default: begin
        nxt_state = S_IDLE;
        nxt_owner = O_NONE;
      end
    endcase
  end

  // Status is computed from the state being entered so the registered
  // output lines up with that state's cycle.
  function automatic logic [1:0] stat_of(input logic is_owner, input logic req,
                                         input logic entering_done);
    if (is_owner && entering_done) return ST_HANDLED;
    else if (is_owner || req)      return ST_BUSY;
    else                           return ST_IDLE;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      owner         <= O_NONE;
      cnt           <= 3'd0;
      len           <= 3'd0;
      base          <= '0;
      sel           <= 1'b0;
      wdata_q       <= 32'd0;
      rd_buf        <= 32'd0;
      bus.if_stat   <= ST_IDLE;
      bus.mem_stat  <= ST_IDLE;
      bus.if_data   <= 32'd0;
      bus.mem_din   <= 32'd0;
      bus.ram_addr  <= '0;
      bus.ram_wr    <= 1'b0;
      bus.ram_wdata <= 8'd0;
`ifdef MEMCTRL_IFETCH_BUF_EN
      fb_valid      <= 1'b0;
      fb_tag        <= '0;
      fb_data       <= 32'd0;
`endif
    end else begin
      state        <= nxt_state;
      owner        <= nxt_owner;
      bus.if_stat  <= stat_of(nxt_owner == O_IF,  bus.if_req, nxt_state == S_DONE);
      bus.mem_stat <= stat_of(nxt_owner == O_MEM, bus.mem_en, nxt_state == S_DONE);

      case (state)
        S_IDLE: begin
          if (bus.mem_en) begin
            base         <= bus.mem_addr[RAM_ADDR_W-1:0];
            sel          <= bus.mem_sel;
            len          <= req_len;
            wdata_q      <= bus.mem_dout;
            cnt          <= 3'd0;
            rd_buf       <= 32'd0;
            // First address/byte go out with the grant; BUSY issues the rest.
            bus.ram_addr <= bus.mem_addr[RAM_ADDR_W-1:0];
            if (bus.mem_sel) begin
              bus.ram_wr    <= 1'b1;
              bus.ram_wdata <= bus.mem_dout[7:0];
`ifdef MEMCTRL_IFETCH_BUF_EN
              fb_valid      <= 1'b0;
`endif
            end
          end else if (bus.if_req) begin
            base   <= bus.if_addr[RAM_ADDR_W-1:0];
            sel    <= 1'b0;
            len    <= 3'd4;
            cnt    <= 3'd0;
            rd_buf <= 32'd0;
            if (fb_hit) begin
`ifdef MEMCTRL_IFETCH_BUF_EN
              bus.if_data <= fb_data;
`endif
            end else begin
              bus.ram_addr <= bus.if_addr[RAM_ADDR_W-1:0];
            end
          end
        end

        S_BUSY: begin
          if (sel) begin
            if (wr_last) begin
              bus.ram_wr    <= 1'b0;
              bus.ram_wdata <= 8'd0;
            end else begin
              cnt           <= cnt_nx;
              bus.ram_addr  <= addr_nx;
              bus.ram_wdata <= wdata_q[{cnt_nx[1:0], 3'b000} +: 8];
            end
          end else if (rd_last) begin
            if (owner == O_IF) begin
              bus.if_data <= done_word;
`ifdef MEMCTRL_IFETCH_BUF_EN
              fb_valid    <= (base[1:0] == 2'b00);
              fb_tag      <= base[RAM_ADDR_W-1:2];
              fb_data     <= done_word;
`endif
            end else begin
              bus.mem_din <= done_word;
            end
          end else begin
            if (cnt != 3'd0) rd_buf <= done_word;
            cnt <= cnt_nx;
            if (cnt_nx < len) bus.ram_addr <= addr_nx;
          end
        end

        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb/tb_mem_ctrl.sv - self-checking bench for mem_ctrl with scoreboarded read data

module tb_mem_ctrl;
  localparam int AW = 17;
`ifdef MEMCTRL_IFETCH_BUF_EN
  localparam bit BUF_EN = 1'b1;
`else
  localparam bit BUF_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_ctrl_if #(.RAM_ADDR_W(AW)) bus ();
  mem_ctrl #(.RAM_ADDR_W(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

  // RAM model: written only by the DUT, read data one cycle after address.
  logic [7:0] ram [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (bus.ram_wr) ram[bus.ram_addr] <= bus.ram_wdata;
    bus.ram_rdata <= ram[bus.ram_addr];
  end

  // Bench-side view of RAM contents, updated when stores are issued.
  logic [7:0] shadow [0:(1<<AW)-1];

  int checks = 0;
  int errors = 0;
  logic [31:0] mem_sb[$];
  logic [31:0] if_sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] shadow_read(input logic [31:0] addr, input int n);
    logic [31:0]   r;
    logic [AW-1:0] a;
    r = 32'd0;
    for (int i = 0; i < n; i++) begin
      a = addr[AW-1:0] + AW'(i);
      r[8*i +: 8] = shadow[a];
    end
    return r;
  endfunction

  task automatic mem_txn(input logic sel, input logic [1:0] typ,
                         input logic [31:0] addr, input logic [31:0] dout);
    int n, hc, wr_cnt;
    logic [AW-1:0] a;
    n  = (typ == 2'b00) ? 1 : (typ == 2'b01) ? 2 : 4;
    hc = sel ? n + 1 : n + 2;
    wr_cnt = 0;
    if (sel) begin
      for (int i = 0; i < n; i++) begin
        a = addr[AW-1:0] + AW'(i);
        shadow[a] = dout[8*i +: 8];
      end
    end else begin
      mem_sb.push_back(shadow_read(addr, n));
    end
    bus.mem_en = 1'b1; bus.mem_sel = sel; bus.mem_type = typ;
    bus.mem_addr = addr; bus.mem_dout = dout;
    for (int c = 1; c <= hc + 1; c++) begin
      @(negedge clk);
      if (c == 1) bus.mem_en = 1'b0;
      if (bus.ram_wr) wr_cnt++;
      if (c <= n) begin
        a = addr[AW-1:0] + AW'(c - 1);
        chk("mem_ram_addr", 32'(bus.ram_addr), 32'(a));
        if (sel) chk("mem_wdata", 32'(bus.ram_wdata), 32'(dout[8*(c-1) +: 8]));
      end
      chk("mem_stat", 32'(bus.mem_stat), (c == hc) ? 32'd2 : ((c > hc) ? 32'd0 : 32'd1));
      if (bus.mem_stat == 2'b10 && !sel) begin
        chk("mem_sb_avail", 32'(mem_sb.size() > 0), 32'd1);
        if (mem_sb.size() > 0) chk("mem_din", bus.mem_din, mem_sb.pop_front());
      end
    end
    chk("ram_wr_count", 32'(wr_cnt), sel ? 32'(n) : 32'd0);
  endtask

  task automatic if_txn(input logic [31:0] addr, input bit hit);
    int hc;
    logic [AW-1:0] a;
    hc = hit ? 1 : 6;
    if_sb.push_back(shadow_read(addr, 4));
    bus.if_req = 1'b1; bus.if_addr = addr;
    for (int c = 1; c <= hc + 1; c++) begin
      @(negedge clk);
      if (c == 1) bus.if_req = 1'b0;
      if (!hit && c <= 4) begin
        a = addr[AW-1:0] + AW'(c - 1);
        chk("if_ram_addr", 32'(bus.ram_addr), 32'(a));
      end
      chk("if_ram_wr", 32'(bus.ram_wr), 32'd0);
      chk("if_stat", 32'(bus.if_stat), (c == hc) ? 32'd2 : ((c > hc) ? 32'd0 : 32'd1));
      if (bus.if_stat == 2'b10) begin
        chk("if_sb_avail", 32'(if_sb.size() > 0), 32'd1);
        if (if_sb.size() > 0) chk("if_data", bus.if_data, if_sb.pop_front());
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.if_req = 1'b0; bus.if_addr = 32'd0;
    bus.mem_en = 1'b0; bus.mem_sel = 1'b0; bus.mem_type = 2'b00;
    bus.mem_addr = 32'd0; bus.mem_dout = 32'd0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_if_stat",   32'(bus.if_stat),   32'd0);
    chk("rst_mem_stat",  32'(bus.mem_stat),  32'd0);
    chk("rst_if_data",   bus.if_data,        32'd0);
    chk("rst_mem_din",   bus.mem_din,        32'd0);
    chk("rst_ram_addr",  32'(bus.ram_addr),  32'd0);
    chk("rst_ram_wr",    32'(bus.ram_wr),    32'd0);
    chk("rst_ram_wdata", 32'(bus.ram_wdata), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Word store then word load at 0x100 (bytes 11,22,33,44)
    mem_txn(1'b1, 2'b10, 32'h0000_0100, 32'h4433_2211);
    mem_txn(1'b0, 2'b10, 32'h0000_0100, 32'h0);
    // Type 11 behaves as a word
    mem_txn(1'b0, 2'b11, 32'h0000_0100, 32'h0);

    // Byte store: single write of EF at 0x20
    mem_txn(1'b1, 2'b00, 32'h0000_0020, 32'hABCD_12EF);
    // Half store, then byte and half loads with zero upper bytes
    mem_txn(1'b1, 2'b01, 32'h0000_0030, 32'h1234_BEEF);
    mem_txn(1'b0, 2'b00, 32'h0000_0031, 32'h0);
    mem_txn(1'b0, 2'b01, 32'h0000_0030, 32'h0);

    // Wrap: half read across the top of the RAM space
    mem_txn(1'b1, 2'b00, 32'h0001_FFFF, 32'h0000_00A5);
    mem_txn(1'b1, 2'b00, 32'h0000_0000, 32'h0000_005A);
    mem_txn(1'b0, 2'b01, 32'h0001_FFFF, 32'h0);

    // Simultaneous requests: MEM wins, IF stays Busy, IF granted after MEM
    mem_txn(1'b1, 2'b10, 32'h0000_0200, 32'h8765_4321);
    mem_txn(1'b1, 2'b10, 32'h0000_0300, 32'h0BAD_F00D);
    mem_sb.push_back(shadow_read(32'h200, 4));
    if_sb.push_back(shadow_read(32'h300, 4));
    bus.mem_en = 1'b1; bus.mem_sel = 1'b0; bus.mem_type = 2'b10; bus.mem_addr = 32'h200;
    bus.if_req = 1'b1; bus.if_addr = 32'h300;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (c == 1) bus.mem_en = 1'b0;
      if (c == 8) bus.if_req = 1'b0;
      chk("arb_mem_stat", 32'(bus.mem_stat), (c < 6) ? 32'd1 : ((c == 6) ? 32'd2 : 32'd0));
      chk("arb_if_stat",  32'(bus.if_stat),  (c < 13) ? 32'd1 : ((c == 13) ? 32'd2 : 32'd0));
      if (c >= 8 && c <= 11) chk("arb_if_ram_addr", 32'(bus.ram_addr), 32'h300 + 32'(c - 8));
      if (bus.mem_stat == 2'b10) begin
        chk("arb_mem_sb_avail", 32'(mem_sb.size() > 0), 32'd1);
        if (mem_sb.size() > 0) chk("arb_mem_din", bus.mem_din, mem_sb.pop_front());
      end
      if (bus.if_stat == 2'b10) begin
        chk("arb_if_sb_avail", 32'(if_sb.size() > 0), 32'd1);
        if (if_sb.size() > 0) chk("arb_if_data", bus.if_data, if_sb.pop_front());
      end
    end

    // Reset taken in cycle 2 of a word store
    bus.mem_en = 1'b1; bus.mem_sel = 1'b1; bus.mem_type = 2'b10;
    bus.mem_addr = 32'h500; bus.mem_dout = 32'hDEAD_BEEF;
    @(negedge clk);
    bus.mem_en = 1'b0;
    chk("rstw_c1_wr", 32'(bus.ram_wr), 32'd1);
    @(negedge clk);
    chk("rstw_c2_wr",   32'(bus.ram_wr),   32'd1);
    chk("rstw_c2_addr", 32'(bus.ram_addr), 32'h501);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstw_c3_wr",       32'(bus.ram_wr),   32'd0);
    chk("rstw_c3_mem_stat", 32'(bus.mem_stat), 32'd0);
    chk("rstw_c3_if_stat",  32'(bus.if_stat),  32'd0);
    for (int c = 4; c <= 10; c++) begin
      @(negedge clk);
      chk("rstw_after_wr",   32'(bus.ram_wr),   32'd0);
      chk("rstw_after_stat", 32'(bus.mem_stat), 32'd0);
    end
    shadow[17'h500] = 8'hEF;
    shadow[17'h501] = 8'hBE;

    // Fetch buffer: repeat fetch hits when enabled; a store invalidates it
    mem_txn(1'b1, 2'b10, 32'h0000_0400, 32'h0403_0201);
    if_txn(32'h0000_0400, 1'b0);
    if_txn(32'h0000_0400, BUF_EN);
    mem_txn(1'b1, 2'b10, 32'h0000_0400, 32'hCAFE_F00D);
    if_txn(32'h0000_0400, 1'b0);

    chk("mem_sb_drained", 32'(mem_sb.size()), 32'd0);
    chk("if_sb_drained",  32'(if_sb.size()),  32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Sequencing and arbitration controller for the single byte-wide RAM port. Shares that port between instruction fetch (IF) and the MEM stage's load/store path. Breaks each byte/half/word request into byte-serial RAM cycles and assembles or scatters little-endian data. Reports per-requester Idle/Busy/Handled status, which the stages use to hold their stall requests.

## Interface
Parameters:
- RAM_ADDR_W, 17, RAM address width; request addresses are truncated to this width.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- if_req  in  1  IF fetch request (always a word read)
- if_addr  in  32  IF byte address
- if_stat  out  2  IF status: 00 Idle, 01 Busy, 10 Handled
- if_data  out  32  fetched word, valid while if_stat=Handled
- mem_en  in  1  MEM access request
- mem_sel  in  1  0 read, 1 write
- mem_type  in  2  00 byte, 01 half, 10 word (11 treated as word)
- mem_addr  in  32  MEM byte address
- mem_dout  in  32  store data, low bytes used
- mem_stat  out  2  MEM status, same encoding as if_stat
- mem_din  out  32  load data, zero-extended raw bytes, valid while mem_stat=Handled
- ram_addr  out  RAM_ADDR_W  RAM byte address
- ram_wr  out  1  RAM write strobe
- ram_wdata  out  8  RAM write byte
- ram_rdata  in  8  RAM read byte, valid one cycle after its address is presented

## Operation
- States: IDLE, BUSY, DONE. Owner register: NONE/IF/MEM. Byte counter cnt[2:0]. Length N = 1/2/4 from the type; IF is always 4.
- IDLE: if mem_en, grant MEM; else if if_req, grant IF. MEM has fixed priority. Latch address, sel, N, and store data; cnt=0; go BUSY.
- BUSY read:
  - ram_addr = base + cnt for cnt < N.
  - For cnt ≥ 1, capture ram_rdata into byte lane cnt-1.
  - Leave when cnt = N, after capturing the last byte.
- BUSY write: ram_wr=1, ram_addr = base + cnt, ram_wdata = store byte cnt. Leave when cnt = N-1.
- DONE: owner's stat = Handled for exactly one cycle with data valid. Other requesters' requests are ignored. Return to IDLE. The next grant is decided in IDLE on the following cycle.
- Status while not DONE: owner sees Busy. A non-owner with its request high sees Busy. Otherwise Idle.
- Address arithmetic: base = addr[RAM_ADDR_W-1:0]; base + cnt wraps modulo 2^RAM_ADDR_W.
- Unused upper bytes of mem_din are 0. Sign extension belongs to the requester.
- A request dropped mid-transaction does not abort it. The transfer completes and Handled is still pulsed.
- Outside a write, ram_wr = 0 and ram_wdata = 0. ram_addr holds its last value.

## Timing
- Reset: state IDLE, owner NONE, cnt 0, if_stat/mem_stat 00, if_data/mem_din 0, ram_addr 0, ram_wr 0, ram_wdata 0. All outputs are registered.
- Reset taken mid-transaction: the next cycle is IDLE with ram_wr=0. The partial write is not completed and no Handled is issued.
- Let the request be sampled in IDLE at edge E0.
  - Read of N bytes: addresses presented in cycles 1..N; Handled in cycle N+2. Word read: Handled 6 cycles after E0.
  - Write of N bytes: ram_wr high in cycles 1..N; Handled in cycle N+1.
- Back-to-back: at least one IDLE cycle separates transactions, so a requester whose request is still high in the DONE cycle is not re-granted from that cycle.

## Configuration
- MEMCTRL_IFETCH_BUF_EN defined: adds a one-entry fetch buffer holding the word address and data of the last completed IF read, plus a valid bit.
  - An IF request granted in IDLE whose address matches the buffer skips BUSY and goes to DONE, with Handled in cycle 1.
  - Any MEM write clears the valid bit when granted. Reset clears it.
- Not defined: every IF request goes through BUSY. No buffer storage exists.

## Test plan
- Word load: mem_en=1, sel=0, type=10, addr=0x100; RAM bytes 11,22,33,44 -> ram_addr 0x100..0x103 in cycles 1-4; mem_stat=10 in cycle 6; mem_din=0x44332211.
- Byte store: type=00, addr=0x20, dout=0xABCD12EF -> one cycle with ram_wr=1, ram_addr=0x20, ram_wdata=0xEF; mem_stat=10 in cycle 2; no other RAM writes.
- Simultaneous if_req and mem_en in IDLE -> MEM granted; if_stat=01 throughout; IF granted on the IDLE cycle after MEM's Handled.
- Wrap: half read at addr 0x1FFFF -> ram_addr 0x1FFFF then 0x00000; mem_din={16'h0, byte@0x0, byte@0x1FFFF}.
- Reset asserted in cycle 2 of a word store -> the next cycle has ram_wr=0 and both stats 00; no Handled pulse follows.
- With MEMCTRL_IFETCH_BUF_EN: two IF reads of 0x400 -> the second gives Handled in cycle 1 with an identical word. An intervening sw to 0x400 forces the full 6-cycle path and returns the new word.
